// File: rtl/fp_norm_pkg.sv
// Shared types for the normalize/round pipeline: rounding-mode encoding,
// the stage-1 to stage-2 control word and the exponent all-ones constant.
package fp_norm_pkg;

    typedef enum logic [1:0] {
        RM_RNE = 2'd0,
        RM_RTZ = 2'd1,
        RM_RUP = 2'd2,
        RM_RDN = 2'd3
    } round_mode_e;

    // Sliced down to EXP_W by the user; covers any exponent up to 32 bits.
    localparam logic [31:0] EXP_ALL_ONES = 32'hFFFF_FFFF;

    typedef struct packed {
        logic        sign;
        round_mode_e mode;
        logic        bypass;
        logic        is_zero;
        logic        is_sub;
    } s1_ctrl_t;

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter; count_o equals W when the input is all zero.
module fp_lzc #(
    parameter int W  = 27,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  data_i,
    output logic [CW-1:0] count_o,
    output logic          zero_o
);

    always_comb begin
        count_o = CW'(W);
        // Scan upward so the most significant set bit wins.
        for (int i = 0; i < W; i++) begin
            if (data_i[i]) begin
                count_o = CW'(W - 1 - i);
            end
        end
        zero_o = ~|data_i;
    end

endmodule

// File: rtl/fp_normalize_round_pipe.sv
// Two-stage normalize / round / pack pipeline for the FP adder result path.
// Define FP_NORM_FTZ_EN to flush would-be subnormal results to signed zero.
module fp_normalize_round_pipe
    import fp_norm_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int RES_W = MAN_W + 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sign,
    input  logic [EXP_W-1:0]         in_exp,
    input  logic [RES_W-1:0]         in_mant,
    input  logic                     in_sticky,
    input  logic [1:0]               in_round_mode,
    input  logic                     in_bypass,
    input  logic [EXP_W+MAN_W:0]     in_bypass_word,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_result,
    output logic                     out_overflow,
    output logic                     out_underflow,
    output logic                     out_inexact
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int NW = RES_W - 1;
    localparam int CW = $clog2(NW + 1);
    localparam int XW = EXP_W + 2;
    localparam logic [EXP_W-1:0] EXP_ONES = EXP_ALL_ONES[EXP_W-1:0];
    localparam logic [EXP_W-1:0] EXP_MAXF = EXP_ONES - 1'b1;

    logic            s1_valid_q, s2_valid_q, s1_adv;
    s1_ctrl_t        s1_ctrl_d, s1_ctrl_q;
    logic [XW-1:0]   s1_exp_d, s1_exp_q;
    logic [NW-1:0]   s1_mant_d, s1_mant_q;
    logic [W-1:0]    s1_word_q;
    logic [W-1:0]    s2_result_d, s2_result_q;
    logic            s2_ovf_d, s2_ovf_q, s2_unf_d, s2_unf_q, s2_inx_d, s2_inx_q;

    logic [CW-1:0]   lzc;
    logic            lzc_zero;
    logic [XW-1:0]   exp_x, lzc_x;

    assign s1_adv   = !s2_valid_q || out_ready;
    assign in_ready = !reset && (!s1_valid_q || s1_adv);

    fp_lzc #(.W(NW), .CW(CW)) u_lzc (
        .data_i  (in_mant[NW-1:0]),
        .count_o (lzc),
        .zero_o  (lzc_zero)
    );

    assign exp_x = XW'(in_exp);
    assign lzc_x = XW'(lzc);

    // Stage 1: normalize so the hidden bit sits at NW-1 with sticky folded into bit 0.
    always_comb begin
        s1_ctrl_d.sign    = in_sign;
        s1_ctrl_d.mode    = round_mode_e'(in_round_mode);
        s1_ctrl_d.bypass  = in_bypass;
        s1_ctrl_d.is_zero = 1'b0;
        s1_ctrl_d.is_sub  = 1'b0;
        s1_exp_d          = exp_x;
        s1_mant_d         = in_mant[NW-1:0];
        if (in_mant[RES_W-1]) begin
            s1_mant_d    = in_mant[RES_W-1:1];
            s1_mant_d[0] = in_mant[1] | in_mant[0] | in_sticky;
            s1_exp_d     = exp_x + XW'(1);
        end else if (lzc_zero) begin
            s1_exp_d  = '0;
            s1_mant_d = {{(NW-1){1'b0}}, in_sticky};
            if (!in_sticky) begin
                s1_ctrl_d.is_zero = 1'b1;
                s1_ctrl_d.sign    = (in_round_mode == RM_RDN);
            end else begin
                s1_ctrl_d.is_sub = 1'b1;
            end
        end else begin
            if (lzc_x < exp_x) begin
                s1_mant_d = in_mant[NW-1:0] << lzc;
                s1_exp_d  = exp_x - lzc_x;
            end else begin
                s1_mant_d        = in_mant[NW-1:0] << (exp_x - XW'(1));
                s1_exp_d         = '0;
                s1_ctrl_d.is_sub = 1'b1;
            end
            s1_mant_d[0] = s1_mant_d[0] | in_sticky;
        end
    end

    logic              g_bit, r_bit, s_bit, lsb, grs, inc, to_inf;
    logic [MAN_W:0]    sig;
    logic [MAN_W+1:0]  sum;
    logic [XW-1:0]     exp_f;

    assign sig   = s1_mant_q[NW-1:3];
    assign lsb   = s1_mant_q[3];
    assign g_bit = s1_mant_q[2];
    assign r_bit = s1_mant_q[1];
    assign s_bit = s1_mant_q[0];
    assign grs   = g_bit | r_bit | s_bit;

    always_comb begin
        inc    = 1'b0;
        to_inf = 1'b0;
        case (s1_ctrl_q.mode)
            RM_RNE: begin inc = g_bit & (r_bit | s_bit | lsb); to_inf = 1'b1;            end
            RM_RTZ: begin inc = 1'b0;                          to_inf = 1'b0;            end
            RM_RUP: begin inc = !s1_ctrl_q.sign & grs;         to_inf = !s1_ctrl_q.sign; end
            RM_RDN: begin inc = s1_ctrl_q.sign & grs;          to_inf = s1_ctrl_q.sign;  end
            default: begin inc = 1'b0; to_inf = 1'b0; end
        endcase
    end

    // A subnormal rounding into the hidden bit bumps the exponent field 0 -> 1.
    assign sum   = {1'b0, sig} + {{(MAN_W+1){1'b0}}, inc};
    assign exp_f = s1_exp_q + XW'(s1_ctrl_q.is_sub ? sum[MAN_W] : sum[MAN_W+1]);

    // Stage 2: round, detect overflow/underflow, pack.
    always_comb begin
        s2_result_d = {s1_ctrl_q.sign, exp_f[EXP_W-1:0], sum[MAN_W-1:0]};
        s2_ovf_d    = 1'b0;
        s2_unf_d    = 1'b0;
        s2_inx_d    = grs;
        if (s1_ctrl_q.bypass) begin
            s2_result_d = s1_word_q;
            s2_inx_d    = 1'b0;
        end else if (s1_ctrl_q.is_zero) begin
            s2_result_d = {s1_ctrl_q.sign, {(W-1){1'b0}}};
            s2_inx_d    = 1'b0;
        end else if (exp_f >= XW'(EXP_ONES)) begin
            s2_ovf_d    = 1'b1;
            s2_inx_d    = 1'b1;
            s2_result_d = to_inf ? {s1_ctrl_q.sign, EXP_ONES, {MAN_W{1'b0}}}
                                 : {s1_ctrl_q.sign, EXP_MAXF, {MAN_W{1'b1}}};
        end else if (exp_f == '0) begin
`ifdef FP_NORM_FTZ_EN
            s2_result_d = {s1_ctrl_q.sign, {(W-1){1'b0}}};
            s2_unf_d    = 1'b1;
            s2_inx_d    = 1'b1;
`else
            s2_unf_d    = grs;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_ctrl_q   <= '0;
            s1_exp_q    <= '0;
            s1_mant_q   <= '0;
            s1_word_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_ovf_q    <= 1'b0;
            s2_unf_q    <= 1'b0;
            s2_inx_q    <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_ctrl_q <= s1_ctrl_d;
                    s1_exp_q  <= s1_exp_d;
                    s1_mant_q <= s1_mant_d;
                    s1_word_q <= in_bypass_word;
                end
            end
            if (s1_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_result_q <= s2_result_d;
                    s2_ovf_q    <= s2_ovf_d;
                    s2_unf_q    <= s2_unf_d;
                    s2_inx_q    <= s2_inx_d;
                end
            end
        end
    end

    assign out_valid     = s2_valid_q;
    assign out_result    = s2_result_q;
    assign out_overflow  = s2_ovf_q;
    assign out_underflow = s2_unf_q;
    assign out_inexact   = s2_inx_q;

endmodule

// File: tb/tb_fp_normalize_round_pipe.sv
// Scoreboard bench for fp_normalize_round_pipe (single precision); expected
// values are hand-derived constants pushed when each beat is accepted.
module tb_fp_normalize_round_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_sign, in_sticky, in_bypass;
    logic [7:0]  in_exp;
    logic [27:0] in_mant;
    logic [1:0]  in_round_mode;
    logic [31:0] in_bypass_word;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic        out_overflow, out_underflow, out_inexact;

    typedef struct {
        string       name;
        logic        s;
        logic [7:0]  e;
        logic [27:0] m;
        logic        st;
        logic [1:0]  rm;
        logic        byp;
        logic [31:0] word;
        logic [31:0] res;
        logic [2:0]  flg;   // {overflow, underflow, inexact}
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [2:0]  flg;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fp_normalize_round_pipe dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_sign        (in_sign),
        .in_exp         (in_exp),
        .in_mant        (in_mant),
        .in_sticky      (in_sticky),
        .in_round_mode  (in_round_mode),
        .in_bypass      (in_bypass),
        .in_bypass_word (in_bypass_word),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_overflow   (out_overflow),
        .out_underflow  (out_underflow),
        .out_inexact    (out_inexact)
    );

    // Inputs change only just after posedge; in_ready is sampled at negedge.
    task automatic drive_beat(input vec_t v);
        bit accepted = 0;
        in_valid = 1'b1; in_sign = v.s; in_exp = v.e; in_mant = v.m; in_sticky = v.st;
        in_round_mode = v.rm; in_bypass = v.byp; in_bypass_word = v.word;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) begin accepted = 1; break; end
        end
        if (!accepted) begin
            checks++; errors++;
            $display("FAIL accept_timeout %s: in_ready=0 required 1", v.name);
        end else begin
            sb_q.push_back('{v.name, v.res, v.flg});
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output logic [31:0] res, output logic [2:0] flg,
                            output int lat, output bit got);
        got = 0; lat = 0; res = '0; flg = '0;
        for (int t = 1; t <= 100; t++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1; lat = t; res = out_result;
                flg = {out_overflow, out_underflow, out_inexact};
                break;
            end
        end
        if (got) begin
            $display("txn result=%h flags=%b latency=%0d", res, flg, lat);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_sign = 0; in_exp = 0; in_mant = 0; in_sticky = 0;
        in_round_mode = 0; in_bypass = 0; in_bypass_word = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_result !== 32'h0 ||
            {out_overflow, out_underflow, out_inexact} !== 3'b000) begin
            errors++;
            $display("FAIL reset_state: valid=%b ready=%b result=%h flags=%b required 0 0 0 000",
                     out_valid, in_ready, out_result, {out_overflow, out_underflow, out_inexact});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_normalize;
        vec_t v[$];
        logic [31:0] r; logic [2:0] f; int lat; bit got; exp_t e;
        v.push_back('{"one_plus_one", 0, 8'd127, 28'h8000000, 0, 2'd0, 0, 32'h0, 32'h40000000, 3'b000});
        v.push_back('{"cancel",       0, 8'd130, 28'h0800000, 0, 2'd0, 0, 32'h0, 32'h3F800000, 3'b000});
        v.push_back('{"carry_sticky", 0, 8'd127, 28'h8000001, 0, 2'd0, 0, 32'h0, 32'h40000000, 3'b001});
        v.push_back('{"carry_rup",    0, 8'd127, 28'h8000001, 0, 2'd2, 0, 32'h0, 32'h40000001, 3'b001});
        v.push_back('{"zero_rdn",     0, 8'd127, 28'h0000000, 0, 2'd3, 0, 32'h0, 32'h80000000, 3'b000});
        v.push_back('{"zero_rne_neg", 1, 8'd127, 28'h0000000, 0, 2'd0, 0, 32'h0, 32'h00000000, 3'b000});
        foreach (v[i]) begin
            drive_beat(v[i]);
            wait_out(r, f, lat, got);
            e = sb_q.pop_front();
            checks++;
            if (!got || r !== e.res || f !== e.flg || lat != 2) begin
                errors++;
                $display("FAIL %s: got=%0d result=%h flags=%b latency=%0d required result=%h flags=%b latency=2",
                         e.name, got, r, f, lat, e.res, e.flg);
            end
        end
    endtask

    task automatic test_round_modes;
        vec_t v[$];
        logic [31:0] r; logic [2:0] f; int lat; bit got; exp_t e;
        v.push_back('{"rne_up",      0, 8'd127, 28'h7FFFFFC, 0, 2'd0, 0, 32'h0, 32'h40000000, 3'b001});
        v.push_back('{"rtz",         0, 8'd127, 28'h7FFFFFC, 0, 2'd1, 0, 32'h0, 32'h3FFFFFFF, 3'b001});
        v.push_back('{"rup_pos",     0, 8'd127, 28'h7FFFFFC, 0, 2'd2, 0, 32'h0, 32'h40000000, 3'b001});
        v.push_back('{"rdn_pos",     0, 8'd127, 28'h7FFFFFC, 0, 2'd3, 0, 32'h0, 32'h3FFFFFFF, 3'b001});
        v.push_back('{"rdn_neg",     1, 8'd127, 28'h7FFFFFC, 0, 2'd3, 0, 32'h0, 32'hC0000000, 3'b001});
        v.push_back('{"rup_neg",     1, 8'd127, 28'h7FFFFFC, 0, 2'd2, 0, 32'h0, 32'hBFFFFFFF, 3'b001});
        v.push_back('{"rne_tie_even",0, 8'd127, 28'h4000004, 0, 2'd0, 0, 32'h0, 32'h3F800000, 3'b001});
        v.push_back('{"rne_sticky",  0, 8'd127, 28'h4000004, 1, 2'd0, 0, 32'h0, 32'h3F800001, 3'b001});
        foreach (v[i]) begin
            drive_beat(v[i]);
            wait_out(r, f, lat, got);
            e = sb_q.pop_front();
            checks++;
            if (!got || r !== e.res || f !== e.flg) begin
                errors++;
                $display("FAIL %s: got=%0d result=%h flags=%b required result=%h flags=%b",
                         e.name, got, r, f, e.res, e.flg);
            end
        end
    endtask

    task automatic test_overflow;
        vec_t v[$];
        logic [31:0] r; logic [2:0] f; int lat; bit got; exp_t e;
        v.push_back('{"ovf_rne",     0, 8'd254, 28'h8000000, 0, 2'd0, 0, 32'h0, 32'h7F800000, 3'b101});
        v.push_back('{"ovf_rtz",     0, 8'd254, 28'h8000000, 0, 2'd1, 0, 32'h0, 32'h7F7FFFFF, 3'b101});
        v.push_back('{"ovf_rup_neg", 1, 8'd254, 28'h8000000, 0, 2'd2, 0, 32'h0, 32'hFF7FFFFF, 3'b101});
        v.push_back('{"ovf_rdn_neg", 1, 8'd254, 28'h8000000, 0, 2'd3, 0, 32'h0, 32'hFF800000, 3'b101});
        v.push_back('{"ovf_by_round",0, 8'd254, 28'h7FFFFFC, 0, 2'd0, 0, 32'h0, 32'h7F800000, 3'b101});
        v.push_back('{"bypass_nan",  0, 8'd254, 28'h8000000, 1, 2'd0, 1, 32'h7FC00000, 32'h7FC00000, 3'b000});
        foreach (v[i]) begin
            drive_beat(v[i]);
            wait_out(r, f, lat, got);
            e = sb_q.pop_front();
            checks++;
            if (!got || r !== e.res || f !== e.flg) begin
                errors++;
                $display("FAIL %s: got=%0d result=%h flags=%b required result=%h flags=%b",
                         e.name, got, r, f, e.res, e.flg);
            end
        end
    endtask

    task automatic test_subnormal;
        vec_t v[$];
        logic [31:0] r; logic [2:0] f; int lat; bit got; exp_t e;
`ifdef FP_NORM_FTZ_EN
        v.push_back('{"sub_exact",   0, 8'd1, 28'h2000000, 0, 2'd0, 0, 32'h0, 32'h00000000, 3'b011});
        v.push_back('{"sub_inexact", 0, 8'd1, 28'h2000004, 0, 2'd1, 0, 32'h0, 32'h00000000, 3'b011});
        v.push_back('{"sub_shift",   0, 8'd3, 28'h0400000, 0, 2'd0, 0, 32'h0, 32'h00000000, 3'b011});
        v.push_back('{"sub_sticky",  0, 8'd1, 28'h0000000, 1, 2'd2, 0, 32'h0, 32'h00000000, 3'b011});
`else
        v.push_back('{"sub_exact",   0, 8'd1, 28'h2000000, 0, 2'd0, 0, 32'h0, 32'h00400000, 3'b000});
        v.push_back('{"sub_inexact", 0, 8'd1, 28'h2000004, 0, 2'd1, 0, 32'h0, 32'h00400000, 3'b011});
        v.push_back('{"sub_shift",   0, 8'd3, 28'h0400000, 0, 2'd0, 0, 32'h0, 32'h00200000, 3'b000});
        v.push_back('{"sub_sticky",  0, 8'd1, 28'h0000000, 1, 2'd2, 0, 32'h0, 32'h00000001, 3'b011});
`endif
        v.push_back('{"sub_to_norm", 0, 8'd1, 28'h3FFFFFC, 0, 2'd0, 0, 32'h0, 32'h00800000, 3'b001});
        foreach (v[i]) begin
            drive_beat(v[i]);
            wait_out(r, f, lat, got);
            e = sb_q.pop_front();
            checks++;
            if (!got || r !== e.res || f !== e.flg) begin
                errors++;
                $display("FAIL %s: got=%0d result=%h flags=%b required result=%h flags=%b",
                         e.name, got, r, f, e.res, e.flg);
            end
        end
    endtask

    task automatic test_back_to_back;
        vec_t a = '{"b2b_a", 0, 8'd127, 28'h8000000, 0, 2'd0, 0, 32'h0, 32'h40000000, 3'b000};
        vec_t b = '{"b2b_byp", 1, 8'd5, 28'h1234567, 1, 2'd2, 1, 32'h7FC00000, 32'h7FC00000, 3'b000};
        vec_t c = '{"b2b_c", 0, 8'd130, 28'h0800000, 0, 2'd0, 0, 32'h0, 32'h3F800000, 3'b000};
        out_ready = 1'b0;
        drive_beat(a);
        drive_beat(b);
        fork
            drive_beat(c);
            begin
                logic [31:0] r; logic [2:0] f; int lat; bit got; exp_t e;
                repeat (4) begin
                    @(negedge clk);
                    checks++;
                    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'h40000000) begin
                        errors++;
                        $display("FAIL hold: in_ready=%b out_valid=%b result=%h required 0 1 40000000",
                                 in_ready, out_valid, out_result);
                    end
                end
                @(posedge clk); #2;
                out_ready = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    wait_out(r, f, lat, got);
                    e = sb_q.pop_front();
                    checks++;
                    if (!got || r !== e.res || f !== e.flg || (k > 0 && lat != 1)) begin
                        errors++;
                        $display("FAIL %s: got=%0d result=%h flags=%b gap=%0d required result=%h flags=%b",
                                 e.name, got, r, f, lat, e.res, e.flg);
                    end
                end
            end
        join
    endtask

    task automatic test_reset_mid;
        vec_t a = '{"mid_a", 0, 8'd127, 28'h8000000, 0, 2'd0, 0, 32'h0, 32'h40000000, 3'b000};
        int seen = 0;
        out_ready = 1'b0;
        drive_beat(a);
        drive_beat(a);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset: out_valid=%b in_ready=%b required 1 0", out_valid, in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_flush: out_valid=%b required 0", out_valid);
        end
        @(posedge clk); #1;
        reset = 1'b0; out_ready = 1'b1;
        sb_q.delete();
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_no_emit: beats_after_reset=%0d required 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_normalize();
        test_round_modes();
        test_overflow();
        test_subnormal();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
